fp_unit_scheduler: RTL

- Round-robin scheduler that shares one fixed-latency, fully pipelined floating-point operator among N_REQ effect requesters.
- Typical shared operators are altfp multipliers and subtractors; typical requesters are distortion gain, tremolo depth and volume stages.
- Issues at most one operand pair per cycle, tags each issue with the requester ID, and routes each result back to its owner after the operator latency.
- Sits between the effect control logic and the shared arithmetic core, in the single audio clock domain.

---
 rtl/fx_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/fp_unit_scheduler.sv | 65 ++++++
 3 files changed

// File: rtl/fx_pkg.sv
// fx_pkg: shared FP constants, altfp operator latencies and the result-routing tag type
package fx_pkg;
  localparam logic [31:0] FP_ONE = 32'h3F800000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF800000;
  localparam int MULT_LAT = 5;
  localparam int SUB_LAT = 7;
  localparam int EXP_LAT = 17;
  localparam int MAX_REQ = 8;
  localparam int TAG_ID_W = $clog2(MAX_REQ);
  typedef struct packed {
    logic valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set req bit above ptr, as one-hot gnt plus index
module rr_arbiter #(
  parameter int N = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx
);
  logic [ID_W-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = ID_W'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt = N'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/fp_unit_scheduler.sv
// fp_unit_scheduler: round-robin sharing of one fixed-latency pipelined FP operator among N_REQ requesters
module fp_unit_scheduler
  import fx_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W = 32,
  parameter int LATENCY = MULT_LAT
) (
  input  logic               clk,
  input  logic               aclr_n,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       unit_a,
  output logic [W-1:0]       unit_b,
  output logic               unit_valid,
  input  logic [W-1:0]       unit_result,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic [5:0]         inflight,
  output logic               idle
);
  localparam int ID_W = $clog2(N_REQ);
  logic [ID_W-1:0] ptr, idx;
  logic [N_REQ-1:0] arb_gnt;
  logic issue, resp;
  tag_t tag_in;
  tag_t [LATENCY:0] tags;
  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(idx)
  );
  assign gnt = (enable && aclr_n) ? arb_gnt : '0;
  assign issue = |gnt;
  assign resp = tags[LATENCY].valid;
  assign tag_in = '{valid: issue, id: TAG_ID_W'(idx)};
  assign idle = (inflight == '0) && !issue;
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ptr <= ID_W'(N_REQ - 1);
      unit_a <= '0;
      unit_b <= '0;
      unit_valid <= 1'b0;
      tags <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      inflight <= '0;
    end else begin
      unit_valid <= issue;
      tags <= {tags[LATENCY-1:0], tag_in};
      rsp_valid <= resp ? N_REQ'(1) << tags[LATENCY].id : '0;
      inflight <= inflight + 6'(issue) - 6'(resp);
      if (issue) begin
        ptr <= idx;
        unit_a <= op_a[idx*W +: W];
        unit_b <= op_b[idx*W +: W];
      end
      if (resp) rsp_data <= unit_result;
    end
  end
endmodule
